countdown_timer: RTL and testbench

- Game countdown timer that sits directly downstream of the 1 Hz timer clock divider.
- Samples the divider's 1 Hz square wave in the 100 MHz domain and converts each rising edge into a one-cycle tick.
- Counts a MM:SS value down in BCD and drives the four digits straight to the seven-segment display mux.
- Provides start/pause/clear control and an expiry flag plus a one-cycle expiry pulse for game logic.

---
 rtl/timer_pkg.sv | 49 ++++
 rtl/tick_edge_sync.sv | 28 ++
 rtl/countdown_timer.sv | 131 +++++++++++++
 tb/tb_countdown_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the MM:SS countdown timer.
// State encoding, BCD digit type and the saturating BCD decrement.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_EXPIRED
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    // One-second decrement; 00:00 stays 00:00.
    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v != '0) begin
            if (v.sec_ones != 4'd0) begin
                r.sec_ones = v.sec_ones - 4'd1;
            end else begin
                r.sec_ones = DIGIT_MAX;
                if (v.sec_tens != 4'd0) begin
                    r.sec_tens = v.sec_tens - 4'd1;
                end else begin
                    r.sec_tens = SEC_TENS_MAX;
                    if (v.min_ones != 4'd0) begin
                        r.min_ones = v.min_ones - 4'd1;
                    end else begin
                        r.min_ones = DIGIT_MAX;
                        r.min_tens = v.min_tens - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises the 1 Hz square wave into the system clock domain
// and emits a one-cycle pulse on each rising edge.
module tick_edge_sync (
    input  logic CLK100M,
    input  logic RST_N,
    input  logic TICK_CLK,
    output logic tick
);

    // bit 0 = s1, bit 1 = s2, bit 2 = s3
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], TICK_CLK};
    end

    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/countdown_timer.sv
// Game countdown timer: BCD MM:SS down-counter with start/pause/clear
// control, driven by synchronised 1 Hz ticks.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned START_MIN = 1,
    parameter int unsigned START_SEC = 0
) (
    input  logic       CLK100M,
    input  logic       RST_N,
    input  logic       TICK_CLK,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       CLEAR,
    output logic [3:0] MIN_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] SEC_ONES,
    output logic       RUNNING,
    output logic       EXPIRED,
    output logic       EXPIRE_PULSE
);

    if (START_MIN > 99 || START_SEC > 59) begin : g_bad_start
        $error("countdown_timer: START_MIN/START_SEC out of range");
    end

    localparam mmss_t LOAD = {
        bcd_t'(START_MIN / 10), bcd_t'(START_MIN % 10),
        bcd_t'(START_SEC / 10), bcd_t'(START_SEC % 10)
    };
    localparam logic  LOAD_ZERO = (START_MIN == 0) && (START_SEC == 0);
    localparam mmss_t ONE_SEC   = 16'h0001;

    logic   tick;
    state_t state_q, state_d;
    mmss_t  cnt_q, cnt_d;
    logic   pulse_q, pulse_d;
    logic   running_q, running_d;
    logic   expired_q, expired_d;

    tick_edge_sync u_tick_sync (
        .CLK100M  (CLK100M),
        .RST_N    (RST_N),
        .TICK_CLK (TICK_CLK),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (CLEAR) begin
            state_d = ST_IDLE;
            cnt_d   = LOAD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (cnt_q == '0) begin
                            state_d = ST_EXPIRED;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Reaching 00:00 beats a coincident PAUSE.
                    if (tick) begin
                        cnt_d = mmss_dec(cnt_q);
                        if (cnt_q == ONE_SEC) begin
                            state_d = ST_EXPIRED;
                            pulse_d = 1'b1;
                        end else if (PAUSE) begin
                            state_d = ST_PAUSED;
                        end
                    end else if (PAUSE) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    // A zero start value re-expires at once.
                    if (START) begin
                        cnt_d = LOAD;
                        if (LOAD_ZERO) begin
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= LOAD;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign MIN_TENS     = cnt_q.min_tens;
    assign MIN_ONES     = cnt_q.min_ones;
    assign SEC_TENS     = cnt_q.sec_tens;
    assign SEC_ONES     = cnt_q.sec_ones;
    assign RUNNING      = running_q;
    assign EXPIRED      = expired_q;
    assign EXPIRE_PULSE = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised scoreboard bench for countdown_timer: three start values
// share one stimulus stream, each checked against a seconds-based model.
module tb_countdown_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic tick_clk = 1'b0;
    logic start    = 1'b0;
    logic pause    = 1'b0;
    logic clear    = 1'b0;

    logic [3:0] mt[3], mo[3], stn[3], so[3];
    logic       run[3], exd[3], pls[3];
    logic [18:0] act[3];

    countdown_timer #(.START_MIN(1), .START_SEC(0)) u_a (
        .CLK100M(clk), .RST_N(rst_n), .TICK_CLK(tick_clk),
        .START(start), .PAUSE(pause), .CLEAR(clear),
        .MIN_TENS(mt[0]), .MIN_ONES(mo[0]),
        .SEC_TENS(stn[0]), .SEC_ONES(so[0]),
        .RUNNING(run[0]), .EXPIRED(exd[0]), .EXPIRE_PULSE(pls[0])
    );

    countdown_timer #(.START_MIN(10), .START_SEC(0)) u_b (
        .CLK100M(clk), .RST_N(rst_n), .TICK_CLK(tick_clk),
        .START(start), .PAUSE(pause), .CLEAR(clear),
        .MIN_TENS(mt[1]), .MIN_ONES(mo[1]),
        .SEC_TENS(stn[1]), .SEC_ONES(so[1]),
        .RUNNING(run[1]), .EXPIRED(exd[1]), .EXPIRE_PULSE(pls[1])
    );

    countdown_timer #(.START_MIN(0), .START_SEC(0)) u_c (
        .CLK100M(clk), .RST_N(rst_n), .TICK_CLK(tick_clk),
        .START(start), .PAUSE(pause), .CLEAR(clear),
        .MIN_TENS(mt[2]), .MIN_ONES(mo[2]),
        .SEC_TENS(stn[2]), .SEC_ONES(so[2]),
        .RUNNING(run[2]), .EXPIRED(exd[2]), .EXPIRE_PULSE(pls[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_act
        assign act[g] = {mt[g], mo[g], stn[g], so[g], run[g], exd[g], pls[g]};
    end

    // Model: remaining time kept as plain seconds.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXP} mstate_e;
    int      load_s[3] = '{60, 600, 0};
    mstate_e mst[3];
    int      rem[3];
    bit      mpulse[3];
    bit [2:0] hist;

    logic [56:0] exp_q[$];
    int ncmp = 0;
    int nmis = 0;
    int cyc  = 0;

    function automatic logic [18:0] exp_obs(int r, mstate_e s, bit p);
        int m, sec;
        m   = r / 60;
        sec = r % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10),
                s == M_RUN, s == M_EXP, p};
    endfunction

    task automatic check(string nm, int inst, logic [18:0] got, logic [18:0] want);
        ncmp++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h",
                     nm, inst, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        hist = 3'b000;
        for (int i = 0; i < 3; i++) begin
            mst[i]    = M_IDLE;
            rem[i]    = load_s[i];
            mpulse[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit tk;
        logic [56:0] e;
        if (!rst_n) begin
            model_reset();
        end else begin
            // A rising edge seen two samples back is acted on now.
            tk   = hist[1] & ~hist[2];
            hist = {hist[1:0], tick_clk};
            for (int i = 0; i < 3; i++) begin
                mpulse[i] = 1'b0;
                if (clear) begin
                    mst[i] = M_IDLE;
                    rem[i] = load_s[i];
                end else begin
                    case (mst[i])
                        M_IDLE: if (start) begin
                            if (rem[i] == 0) begin
                                mst[i] = M_EXP;
                                mpulse[i] = 1'b1;
                            end else mst[i] = M_RUN;
                        end
                        M_RUN: begin
                            if (tk && rem[i] > 0) rem[i]--;
                            if (tk && rem[i] == 0) begin
                                mst[i] = M_EXP;
                                mpulse[i] = 1'b1;
                            end else if (pause) mst[i] = M_PAUSED;
                        end
                        M_PAUSED: if (pause) mst[i] = M_RUN;
                        M_EXP: if (start) begin
                            rem[i] = load_s[i];
                            if (rem[i] == 0) mpulse[i] = 1'b1;
                            else mst[i] = M_RUN;
                        end
                        default: mst[i] = M_IDLE;
                    endcase
                end
            end
        end
        e = {exp_obs(rem[2], mst[2], mpulse[2]),
             exp_obs(rem[1], mst[1], mpulse[1]),
             exp_obs(rem[0], mst[0], mpulse[0])};
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial begin
        logic [56:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    check("outputs", i, act[i], e[19*i +: 19]);
                end
            end
        end
    end

    int tc_left = 6;

    task automatic next_cycle(bit do_tick, int p_start, int p_pause, int p_clear);
        @(negedge clk);
        #2;
        start = (p_start > 0) && ($urandom % p_start == 0);
        pause = (p_pause > 0) && ($urandom % p_pause == 0);
        clear = (p_clear > 0) && ($urandom % p_clear == 0);
        if (do_tick) begin
            tc_left--;
            if (tc_left <= 0) begin
                tick_clk = ~tick_clk;
                tc_left  = int'($urandom_range(3, 8));
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("async_reset", i, act[i], exp_obs(load_s[i], M_IDLE, 1'b0));
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        // Free-running TICK_CLK with no START: digits must not move.
        repeat (60) next_cycle(1'b1, 0, 0, 0);
        @(negedge clk);
        #2;
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        // Uninterrupted countdown so the 01:00 instance expires.
        repeat (900) next_cycle(1'b1, 0, 0, 0);
        // Reset while TICK_CLK is held high, then a START soon after.
        tick_clk = 1'b1;
        pulse_reset();
        repeat (2) next_cycle(1'b0, 0, 0, 0);
        @(negedge clk);
        #2;
        start = 1'b1;
        repeat (40) next_cycle(1'b0, 0, 0, 0);
        for (int n = 0; n < 24000; n++) begin
            if ($urandom % 6000 == 0) pulse_reset();
            else next_cycle(1'b1, 30, 70, 2500);
        end
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
